// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the memory request path
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_IF   = 2'b01,
    GNT_LSB  = 2'b10,
    DONE_GAP = 2'b11
  } arb_state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  // Memory-mapped IO lives in the top quarter of the 18-bit physical space
  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - single-outstanding IF/LSB arbiter in front of memory_controller
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [63:0] if_data,
  output logic        if_done,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic        lsb_signed,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_done,
  output logic        mc_instr_signal,
  output logic [31:0] mc_instr_a,
  input  logic [63:0] mc_instr_d,
  input  logic        mc_instr_done,
  output logic        mc_lsb_signal,
  output logic        mc_lsb_wr,
  output logic        mc_lsb_signed,
  output logic [1:0]  mc_lsb_len,
  output logic [31:0] mc_lsb_a,
  output logic [31:0] mc_lsb_din,
  input  logic [31:0] mc_lsb_dout,
  input  logic        mc_lsb_done
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             isig_d, lsig_d, lwr_d, lsgn_d, idone_d, ldone_d;
  logic [1:0]       llen_d;
  logic [31:0]      ia_d, la_d, ldin_d, rdata_d;
  logic [63:0]      idata_d;

  // Next-state, arbitration, starvation counter and next values of every registered output
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isig_d  = mc_instr_signal;
    ia_d    = mc_instr_a;
    lsig_d  = mc_lsb_signal;
    lwr_d   = mc_lsb_wr;
    lsgn_d  = mc_lsb_signed;
    llen_d  = mc_lsb_len;
    la_d    = mc_lsb_a;
    ldin_d  = mc_lsb_din;
    idata_d = if_data;
    rdata_d = lsb_rdata;
    idone_d = 1'b0;
    ldone_d = 1'b0;

    // Nobody is starving while LSB is not asking
    if (!lsb_req) cnt_d = '0;

    case (state_q)
      IDLE: begin
        // A flush in the same cycle as a request suppresses the grant
        if (!clear_signal) begin
          if (lsb_req && (cnt_q == LIMIT || !if_req)) begin
            state_d = GNT_LSB;
            cnt_d   = '0;
            lsig_d  = 1'b1;
            lwr_d   = lsb_wr;
            lsgn_d  = lsb_signed;
            llen_d  = lsb_len;
            la_d    = lsb_addr;
            ldin_d  = lsb_wdata;
          end else if (if_req) begin
            state_d = GNT_IF;
            isig_d  = 1'b1;
            ia_d    = if_addr;
            if (lsb_req && cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GNT_IF: begin
        // Clear takes priority; a done arriving alongside it is thrown away
        if (clear_signal) begin
          state_d = DONE_GAP;
          isig_d  = 1'b0;
        end else if (mc_instr_done) begin
          state_d = DONE_GAP;
          isig_d  = 1'b0;
          idata_d = mc_instr_d;
          idone_d = 1'b1;
        end
      end
      GNT_LSB: begin
        // Stores have already committed architecturally, so a flush never cancels them
        if (clear_signal && !mc_lsb_wr) begin
          state_d = DONE_GAP;
          lsig_d  = 1'b0;
        end else if (mc_lsb_done) begin
          state_d = DONE_GAP;
          lsig_d  = 1'b0;
          rdata_d = mc_lsb_dout;
          ldone_d = 1'b1;
        end
      end
      default: begin
        // One dead cycle lets the controller fall back to FREE and clear its done flag
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; pause freezes everything but kills the done pulses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      mc_instr_signal <= 1'b0;
      mc_instr_a      <= '0;
      mc_lsb_signal   <= 1'b0;
      mc_lsb_wr       <= 1'b0;
      mc_lsb_signed   <= 1'b0;
      mc_lsb_len      <= '0;
      mc_lsb_a        <= '0;
      mc_lsb_din      <= '0;
      if_data         <= '0;
      lsb_rdata       <= '0;
      if_done         <= 1'b0;
      lsb_done        <= 1'b0;
    end else if (!rdy_in) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mc_instr_signal <= isig_d;
      mc_instr_a      <= ia_d;
      mc_lsb_signal   <= lsig_d;
      mc_lsb_wr       <= lwr_d;
      mc_lsb_signed   <= lsgn_d;
      mc_lsb_len      <= llen_d;
      mc_lsb_a        <= la_d;
      mc_lsb_din      <= ldin_d;
      if_data         <= idata_d;
      lsb_rdata       <= rdata_d;
      if_done         <= idone_d;
      lsb_done        <= ldone_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed vector bench for mem_req_arbiter
module tb_mem_req_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal;
  logic        if_req, if_done;
  logic [31:0] if_addr;
  logic [63:0] if_data;
  logic        lsb_req, lsb_wr, lsb_signed, lsb_done;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        mc_instr_signal, mc_instr_done;
  logic [31:0] mc_instr_a;
  logic [63:0] mc_instr_d;
  logic        mc_lsb_signal, mc_lsb_wr, mc_lsb_signed, mc_lsb_done;
  logic [1:0]  mc_lsb_len;
  logic [31:0] mc_lsb_a, mc_lsb_din, mc_lsb_dout;

  always #5 clk_in = ~clk_in;

  mem_req_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done),
    .mc_instr_signal(mc_instr_signal), .mc_instr_a(mc_instr_a), .mc_instr_d(mc_instr_d),
    .mc_instr_done(mc_instr_done), .mc_lsb_signal(mc_lsb_signal), .mc_lsb_wr(mc_lsb_wr),
    .mc_lsb_signed(mc_lsb_signed), .mc_lsb_len(mc_lsb_len), .mc_lsb_a(mc_lsb_a),
    .mc_lsb_din(mc_lsb_din), .mc_lsb_dout(mc_lsb_dout), .mc_lsb_done(mc_lsb_done)
  );

  localparam logic [63:0] ID = 64'h00A0_0513_0000_0093;
  localparam logic [31:0] RD = 32'h1234_5678;
  localparam logic [31:0] IA = 32'h0000_0100;

  typedef struct {
    logic        rst, rdy, clr, ifr, lsbr, idone, ldone;
    logic        e_isig, e_lsig, e_ifd, e_lsd;
    logic [63:0] e_idata;
    logic [31:0] e_rdata;
    logic [31:0] e_ia;
  } vec_t;

  vec_t vecs[23];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic drive(input logic rst, rdy, clr, ifr, lsbr, idone, ldone);
    @(negedge clk_in);
    rst_in = rst; rdy_in = rdy; clear_signal = clr; if_req = ifr; lsb_req = lsbr;
    mc_instr_done = idone; mc_lsb_done = ldone;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic ok, input string detail);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  initial begin
    logic exp_order[10];
    logic got;
    int   ng;
    int   pulses;
    logic prev_i, prev_l, both;

    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0;
    if_req = 1'b0; if_addr = IA;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = 2'b11;
    lsb_addr = 32'h0000_1000; lsb_wdata = 32'h0;
    mc_instr_d = ID; mc_instr_done = 1'b0; mc_lsb_dout = RD; mc_lsb_done = 1'b0;

    //          rst   rdy   clr   ifr   lsbr  idone ldone isig  lsig  ifd   lsd   idata  rdata  ia
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0};
    // single fetch
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, IA};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, IA};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ID,    32'h0, IA};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    32'h0, IA};
    // load cancelled by clear, with a done in the same cycle discarded
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    32'h0, IA};
    // clear and request together in IDLE: no grant; then a normal load
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ID,    32'h0, IA};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ID,    RD,    IA};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    // pause for 3 cycles during GNT_IF with done offered
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ID,    RD,    IA};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    // reset mid-grant
    vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ID,    RD,    IA};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0};

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].clr, vecs[i].ifr, vecs[i].lsbr, vecs[i].idone, vecs[i].ldone);
      check($sformatf("vec%0d", i),
            mc_instr_signal == vecs[i].e_isig && mc_lsb_signal == vecs[i].e_lsig &&
            if_done == vecs[i].e_ifd && lsb_done == vecs[i].e_lsd &&
            if_data == vecs[i].e_idata && lsb_rdata == vecs[i].e_rdata && mc_instr_a == vecs[i].e_ia,
            $sformatf("got isig=%b lsig=%b ifd=%b lsd=%b idata=%h rdata=%h ia=%h want %b %b %b %b %h %h %h",
                      mc_instr_signal, mc_lsb_signal, if_done, lsb_done, if_data, lsb_rdata, mc_instr_a,
                      vecs[i].e_isig, vecs[i].e_lsig, vecs[i].e_ifd, vecs[i].e_lsd,
                      vecs[i].e_idata, vecs[i].e_rdata, vecs[i].e_ia));
    end

    // store survives a clear
    lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_wdata = 32'hDEAD_BEEF; lsb_len = 2'b11; lsb_signed = 1'b0;
    mc_lsb_dout = 32'h0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("store_grant", mc_lsb_signal && mc_lsb_wr && !mc_lsb_signed && mc_lsb_len == 2'b11 &&
          mc_lsb_a == 32'h0003_0000 && mc_lsb_din == 32'hDEAD_BEEF && !mc_instr_signal,
          $sformatf("got sig=%b wr=%b len=%b a=%h din=%h want 1 1 11 00030000 deadbeef",
                    mc_lsb_signal, mc_lsb_wr, mc_lsb_len, mc_lsb_a, mc_lsb_din));
    lsb_addr = 32'h0; lsb_wdata = 32'h0; lsb_wr = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, (c == 0), 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("store_hold%0d", c), mc_lsb_signal && mc_lsb_a == 32'h0003_0000 && !lsb_done,
            $sformatf("got sig=%b a=%h done=%b want 1 00030000 0", mc_lsb_signal, mc_lsb_a, lsb_done));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("store_done", !mc_lsb_signal && lsb_done,
          $sformatf("got sig=%b done=%b want 0 1", mc_lsb_signal, lsb_done));
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (lsb_done) pulses++;
    end
    check("store_single_pulse", pulses == 0, $sformatf("got %0d extra pulses want 0", pulses));

    // contention with both requests held: IF x4 then LSB, repeating
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ng = 0; prev_i = 1'b0; prev_l = 1'b0; both = 1'b0;
    for (int c = 0; c < 300 && ng < 10; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, mc_instr_signal, mc_lsb_signal);
      if (mc_instr_signal && mc_lsb_signal) both = 1'b1;
      if ((mc_instr_signal && !prev_i) || (mc_lsb_signal && !prev_l)) begin
        got = mc_lsb_signal;
        check($sformatf("grant%0d", ng), got == exp_order[ng],
              $sformatf("got %s want %s", got ? "LSB" : "IF", exp_order[ng] ? "LSB" : "IF"));
        ng++;
      end
      prev_i = mc_instr_signal; prev_l = mc_lsb_signal;
    end
    check("contention_timeout", ng == 10, $sformatf("got %0d grants want 10", ng));
    check("mutual_exclusion", !both, $sformatf("got both=%b want 0", both));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the requesters (instruction fetch / i-cache and the load-store buffer) and memory_controller.
- Presents at most one outstanding request to the controller at a time.
- Replaces the controller's fixed instruction-first priority with IF-priority plus an anti-starvation counter for LSB.
- Handles misprediction clear: cancels in-flight fetches and loads, but never cancels a store.

Parameters:
- STARVE_LIMIT, 4: consecutive IF grants allowed while LSB waits before LSB is forced next.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  low = pause; all state held, no new grants
- clear_signal  in  1  misprediction flush
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_data  out  64  two fetched instructions
- if_done  out  1  one-cycle pulse, if_data valid
- lsb_req  in  1  load/store request, level, held until lsb_done
- lsb_wr  in  1  1 = store
- lsb_signed  in  1  signed load
- lsb_len  in  2  00 = byte, 01 = half, 11 = word
- lsb_addr  in  32  address
- lsb_wdata  in  32  store data
- lsb_rdata  out  32  load data
- lsb_done  out  1  one-cycle pulse
- mc_instr_signal  out  1  to controller instr_signal
- mc_instr_a  out  32  to controller instr_a
- mc_instr_d  in  64  from controller
- mc_instr_done  in  1  from controller
- mc_lsb_signal  out  1  to controller lsb_signal
- mc_lsb_wr, mc_lsb_signed, mc_lsb_len, mc_lsb_a, mc_lsb_din  out  1/1/2/32/32  to controller
- mc_lsb_dout  in  32  from controller
- mc_lsb_done  in  1  from controller

Behaviour:
- Clocking: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset: state = IDLE, starve_cnt = 0, and all outputs 0 (if_data, lsb_rdata, if_done, lsb_done, every mc_* output).
- Output timing: all outputs are registered.
- Pause: when rdy_in = 0, every register holds its value, except if_done and lsb_done, which are forced to 0.
- States: IDLE, GNT_IF, GNT_LSB, DONE_GAP.
- IDLE, clear_signal = 1: no grant.
- IDLE, arbitration otherwise:
  - Grant LSB if lsb_req and (starve_cnt == STARVE_LIMIT or !if_req).
  - Else grant IF if if_req.
  - Grant is registered: request seen in cycle t gives mc_*_signal high in t+1.
  - Request fields are captured into mc_* registers at grant and held stable for the whole grant.
- starve_cnt:
  - On an IF grant while lsb_req = 1: increment, saturating at STARVE_LIMIT.
  - On any LSB grant, or when lsb_req = 0: cleared to 0.
- GNT_IF / GNT_LSB:
  - Hold mc_*_signal high until the matching mc_*_done is sampled high.
  - On that cycle: drop the signal, latch data into if_data / lsb_rdata, pulse if_done / lsb_done next cycle, go to DONE_GAP.
- DONE_GAP:
  - Lasts one cycle and guarantees the controller returns to FREE with its done flag cleared before the next grant.
  - Then IDLE.
  - The requester must have dropped its req by IDLE; a req still high then is treated as a new request.
- Clear during GNT_IF, or GNT_LSB with mc_lsb_wr = 0:
  - Drop the signal next cycle, go to DONE_GAP, no done pulse.
  - Any mc done arriving in the same cycle as clear is discarded.
- Clear during GNT_LSB with mc_lsb_wr = 1: ignored; the store runs to completion and lsb_done pulses normally.
- Clear and a new request in the same IDLE cycle: clear wins, no grant.
- Never assert mc_instr_signal and mc_lsb_signal together.
- At most one grant in flight.

Decomposition:
- Shared package mem_pkg:
  - arbiter state encodings.
  - LEN_BYTE / LEN_HALF / LEN_WORD constants (00/01/11).
  - IO address predicate (addr[17:16] == 2'b11), shared with memory_controller.
- No sub-module. Arbitration and the counter fit in one always block; a separate starvation counter module is not warranted.

Test Plan:
- Single fetch: if_req with if_addr = 0x100; controller model returns 0x00A0_0513_0000_0093 → mc_instr_signal high from cycle 1, if_done one-cycle pulse with that if_data, then DONE_GAP, then IDLE.
- Contention: if_req and lsb_req both held continuously, STARVE_LIMIT = 4 → grant order IF, IF, IF, IF, LSB, IF…; starve_cnt reads 4 at the LSB grant, then 0.
- Load cancel: LSB load (lsb_len = 11, addr 0x1000) granted, clear_signal pulsed mid-transfer → mc_lsb_signal drops next cycle, no lsb_done, IDLE after DONE_GAP.
- Store survives clear: store of 0xDEADBEEF to 0x30000 with clear pulsed at cycle 2 → mc_lsb_signal stays high until mc_lsb_done, then lsb_done pulses once.
- Pause/reset: rdy_in low for 3 cycles during GNT_IF → state and mc_* unchanged, no done pulse; rst_in mid-grant → next cycle all outputs 0, state IDLE.
